dma_tcq_arbiter: RTL and testbench
==================================

# dma_tcq_arbiter

Round-robin arbiter that shares one PCIe mover TX request queue (tcq) between `CHANNELS` TX DMA engines. Each engine presents its own tcq request/completion handshakes. The arbiter registers the selected request toward the mover and tags it with the channel index. It routes mover completions back to the owning channel by tag, and enforces a per-channel outstanding-request limit. It sits between the TX DMA wrapper instances and the PCIe mover.

## Interface
Parameters:
- `CHANNELS`, 2 — number of requesters; power of 2, 2..4.
- `RAM_ADDR_WIDTH`, 17 — local RAM address width.
- `BUS_ADDR_WIDTH`, 32 — host bus address width.
- `DATA_BITS`, 3 — log2 of bytes per data word.
- `REQUEST_LEN_BITS`, 12 — request length width.
- `PCIE_TAG_BITS`, 5 — mover tag width.
- `CH_BITS`, $clog2(CHANNELS) — derived.
- `CH_TAG_BITS`, PCIE_TAG_BITS-CH_BITS — derived; per-channel tag width.
- `MAX_OUTSTANDING`, 2**CH_TAG_BITS — per-channel in-flight limit; 1..2**CH_TAG_BITS.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — synchronous, active-high reset.
- `s_tcq_valid` in CHANNELS — per-channel request valid.
- `s_tcq_ready` out CHANNELS — per-channel request ready.
- `s_tcq_laddr` in CHANNELS*(RAM_ADDR_WIDTH-DATA_BITS) — local address, channel i in slice i.
- `s_tcq_raddr` in CHANNELS*(BUS_ADDR_WIDTH-DATA_BITS) — bus address.
- `s_tcq_length` in CHANNELS*(REQUEST_LEN_BITS-DATA_BITS) — request length.
- `s_tcq_tag` in CHANNELS*CH_TAG_BITS — channel-local tag.
- `s_tcq_cvalid` out CHANNELS — completion valid toward channel.
- `s_tcq_cready` in CHANNELS — completion ready from channel.
- `s_tcq_ctag` out CH_TAG_BITS — completion tag, channel-local; shared bus.
- `m_tcq_valid` out 1 — request valid toward the mover.
- `m_tcq_ready` in 1 — request ready from the mover.
- `m_tcq_laddr` out RAM_ADDR_WIDTH-DATA_BITS — registered local address.
- `m_tcq_raddr` out BUS_ADDR_WIDTH-DATA_BITS — registered bus address.
- `m_tcq_length` out REQUEST_LEN_BITS-DATA_BITS — registered request length.
- `m_tcq_tag` out PCIE_TAG_BITS — `{channel, ch_tag}`.
- `m_tcq_cvalid` in 1 — mover completion valid.
- `m_tcq_cready` out 1 — mover completion ready.
- `m_tcq_ctag` in PCIE_TAG_BITS — mover completion tag.
- `stat_outstanding` out CHANNELS*(CH_TAG_BITS+1) — in-flight count per channel.
- `stat_cpl_underflow` out CHANNELS — sticky flag: completion arrived with count 0.

## Operation
- Eligibility: channel i is eligible when `s_tcq_valid[i] && outstanding[i] < MAX_OUTSTANDING`.
- Load condition: `load = !m_tcq_valid || m_tcq_ready`.
- Grant selection: when `load` is true, grant goes to the first eligible channel searching from `rr_ptr` upward, modulo CHANNELS.
  - Only the granted channel sees `s_tcq_ready[i] = 1`; all other ready bits are 0.
  - Ready is combinational from valid, the counters and `load`.
- Output register: on accept, the output register captures the granted channel's laddr/raddr/length and `tag = {i[CH_BITS-1:0], s_tcq_tag_i}`, and sets `m_tcq_valid = 1`.
  - Then `rr_ptr <= i+1` (wraps).
  - `m_tcq_valid` clears on `m_tcq_ready` when no new accept happens in the same cycle.
- Stability: output payload is held stable while `m_tcq_valid && !m_tcq_ready`.
- Completion routing: `ch = m_tcq_ctag[PCIE_TAG_BITS-1:CH_TAG_BITS]`.
  - `s_tcq_cvalid[ch] = m_tcq_cvalid`; all other cvalid bits are 0.
  - `s_tcq_ctag = m_tcq_ctag[CH_TAG_BITS-1:0]`.
  - `m_tcq_cready = s_tcq_cready[ch]`.
  - The completion path is purely combinational.
- Counters:
  - `outstanding[i]` increments on request accept of channel i and decrements on completion handshake for channel i.
  - Both in the same cycle: the count is unchanged.
  - Decrement at 0: the count stays 0 and `stat_cpl_underflow[i]` is set (sticky until `rst`).
- A channel at `MAX_OUTSTANDING` is skipped; the next eligible channel is granted in the same cycle.

## Timing
- Reset values: `m_tcq_valid=0`, `m_tcq_laddr/raddr/length/tag=0`, `rr_ptr=0`, all `outstanding=0`, `stat_cpl_underflow=0`.
- Reset-time outputs: `s_tcq_ready` is 0 while `rst` is high.
- Request latency: a request accepted at edge N appears on `m_tcq_*` after edge N. Throughput is 1 request/cycle with the mover continuously ready.
- Reset mid-operation: any pending `m_tcq_valid` is dropped and all counters clear. Channels must be reset together with the arbiter.
- Completion latency: 0 cycles, combinational.
- Stat outputs: `stat_outstanding` is registered and reflects edge-updated counts.

## Test plan
- Single channel: CHANNELS=2, ch0 streams 4 requests with `m_tcq_ready=1`. Expect 4 consecutive `m_tcq_valid` cycles, tags `{0,t}`, and `stat_outstanding[0]=4`.
- Contention: both channels valid continuously with mover ready. Expect grants to alternate 0,1,0,1 starting with 0 after reset, and `m_tcq_tag[4]` toggling.
- Backpressure: `m_tcq_ready=0` for 5 cycles with a request loaded. Expect `m_tcq_*` stable, all `s_tcq_ready=0`, and no counter change. On release, the next grant goes to the other channel.
- Limit: MAX_OUTSTANDING=2, ch0 issues 2 requests without completions. Expect `s_tcq_ready[0]=0` while ch1 is still granted. One completion with tag `{0,x}` re-enables ch0 the next cycle.
- Completion routing: `m_tcq_ctag=5'b1_0011` with `s_tcq_cready[1]=0`. Expect `s_tcq_cvalid=2'b10`, `s_tcq_ctag=4'h3`, and `m_tcq_cready=0`. With an accept and a completion for ch1 in the same cycle, the count is unchanged.
- Underflow/reset: a completion for ch0 with count 0 sets `stat_cpl_underflow[0]=1` and keeps the count at 0. Asserting `rst` with `m_tcq_valid=1` gives `m_tcq_valid=0`, and all stats clear one cycle later.

Source files
------------

// File: rtl/dma_tcq_arbiter_if.sv
// Request/completion bundle between the TX DMA channels, the tcq arbiter and the PCIe mover.
// slave is the arbiter's view; master is the view of the channels and mover around it.
interface dma_tcq_arbiter_if #(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned RAM_ADDR_WIDTH   = 17,
  parameter int unsigned BUS_ADDR_WIDTH   = 32,
  parameter int unsigned DATA_BITS        = 3,
  parameter int unsigned REQUEST_LEN_BITS = 12,
  parameter int unsigned PCIE_TAG_BITS    = 5
);
  localparam int unsigned CH_BITS     = $clog2(CHANNELS);
  localparam int unsigned CH_TAG_BITS = PCIE_TAG_BITS - CH_BITS;
  localparam int unsigned LADDR_W     = RAM_ADDR_WIDTH - DATA_BITS;
  localparam int unsigned RADDR_W     = BUS_ADDR_WIDTH - DATA_BITS;
  localparam int unsigned LEN_W       = REQUEST_LEN_BITS - DATA_BITS;

  // Channel side: one slice per channel, channel i in slice i
  logic [CHANNELS-1:0]             s_tcq_valid;
  logic [CHANNELS-1:0]             s_tcq_ready;
  logic [CHANNELS*LADDR_W-1:0]     s_tcq_laddr;
  logic [CHANNELS*RADDR_W-1:0]     s_tcq_raddr;
  logic [CHANNELS*LEN_W-1:0]       s_tcq_length;
  logic [CHANNELS*CH_TAG_BITS-1:0] s_tcq_tag;
  logic [CHANNELS-1:0]             s_tcq_cvalid;
  logic [CHANNELS-1:0]             s_tcq_cready;
  logic [CH_TAG_BITS-1:0]          s_tcq_ctag;

  // Mover side
  logic                     m_tcq_valid;
  logic                     m_tcq_ready;
  logic [LADDR_W-1:0]       m_tcq_laddr;
  logic [RADDR_W-1:0]       m_tcq_raddr;
  logic [LEN_W-1:0]         m_tcq_length;
  logic [PCIE_TAG_BITS-1:0] m_tcq_tag;
  logic                     m_tcq_cvalid;
  logic                     m_tcq_cready;
  logic [PCIE_TAG_BITS-1:0] m_tcq_ctag;

  modport slave (
    input  s_tcq_valid, s_tcq_laddr, s_tcq_raddr, s_tcq_length, s_tcq_tag, s_tcq_cready,
    input  m_tcq_ready, m_tcq_cvalid, m_tcq_ctag,
    output s_tcq_ready, s_tcq_cvalid, s_tcq_ctag,
    output m_tcq_valid, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag, m_tcq_cready
  );

  modport master (
    output s_tcq_valid, s_tcq_laddr, s_tcq_raddr, s_tcq_length, s_tcq_tag, s_tcq_cready,
    output m_tcq_ready, m_tcq_cvalid, m_tcq_ctag,
    input  s_tcq_ready, s_tcq_cvalid, s_tcq_ctag,
    input  m_tcq_valid, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag, m_tcq_cready
  );
endinterface

// File: rtl/dma_tcq_arbiter.sv
// Round-robin share of one PCIe mover tcq among CHANNELS TX DMA engines, with tag-based
// completion return and a per-channel in-flight limit.
module dma_tcq_arbiter #(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned RAM_ADDR_WIDTH   = 17,
  parameter int unsigned BUS_ADDR_WIDTH   = 32,
  parameter int unsigned DATA_BITS        = 3,
  parameter int unsigned REQUEST_LEN_BITS = 12,
  parameter int unsigned PCIE_TAG_BITS    = 5,
  parameter int unsigned CH_BITS          = $clog2(CHANNELS),
  parameter int unsigned CH_TAG_BITS      = PCIE_TAG_BITS - CH_BITS,
  parameter int unsigned MAX_OUTSTANDING  = 2 ** CH_TAG_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  dma_tcq_arbiter_if.slave                     bus,
  output logic [CHANNELS*(CH_TAG_BITS+1)-1:0]  stat_outstanding,
  output logic [CHANNELS-1:0]                  stat_cpl_underflow
);
  localparam int unsigned LADDR_W = RAM_ADDR_WIDTH - DATA_BITS;
  localparam int unsigned RADDR_W = BUS_ADDR_WIDTH - DATA_BITS;
  localparam int unsigned LEN_W   = REQUEST_LEN_BITS - DATA_BITS;
  localparam int unsigned CNT_W   = CH_TAG_BITS + 1;

  logic [CH_BITS-1:0]       rr_ptr;
  logic [CNT_W-1:0]         outstanding [CHANNELS];
  logic [CHANNELS-1:0]      cpl_underflow;

  logic                     m_valid_q;
  logic [LADDR_W-1:0]       m_laddr_q;
  logic [RADDR_W-1:0]       m_raddr_q;
  logic [LEN_W-1:0]         m_length_q;
  logic [PCIE_TAG_BITS-1:0] m_tag_q;

  logic                     load_c;
  logic [CHANNELS-1:0]      eligible_c;
  logic                     grant_found_c;
  logic [CH_BITS-1:0]       grant_idx_c;
  logic [CHANNELS-1:0]      grant_c;
  logic                     accept_c;

  logic [LADDR_W-1:0]       sel_laddr_c;
  logic [RADDR_W-1:0]       sel_raddr_c;
  logic [LEN_W-1:0]         sel_length_c;
  logic [CH_TAG_BITS-1:0]   sel_tag_c;

  logic [CH_BITS-1:0]       cpl_ch_c;
  logic [CHANNELS-1:0]      cpl_valid_c;
  logic                     cpl_hs_c;
  logic [CHANNELS-1:0]      inc_c;
  logic [CHANNELS-1:0]      dec_c;

  // The output slot can take a new request when empty or being drained this cycle
  assign load_c = !m_valid_q || bus.m_tcq_ready;

  always_comb begin
    eligible_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      eligible_c[i] = bus.s_tcq_valid[i] && (outstanding[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Walk from the highest offset down so the channel nearest rr_ptr wins
  always_comb begin
    logic [CH_BITS-1:0] idx;
    idx           = '0;
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      idx = rr_ptr + CH_BITS'(k);
      if (eligible_c[idx]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = idx;
      end
    end
  end

  always_comb begin
    grant_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      grant_c[i] = !rst && load_c && grant_found_c && (grant_idx_c == CH_BITS'(i));
    end
  end

  assign accept_c        = |grant_c;
  assign bus.s_tcq_ready = grant_c;

  // Payload of the granted channel
  always_comb begin
    sel_laddr_c  = '0;
    sel_raddr_c  = '0;
    sel_length_c = '0;
    sel_tag_c    = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (grant_idx_c == CH_BITS'(i)) begin
        sel_laddr_c  = bus.s_tcq_laddr[i*LADDR_W +: LADDR_W];
        sel_raddr_c  = bus.s_tcq_raddr[i*RADDR_W +: RADDR_W];
        sel_length_c = bus.s_tcq_length[i*LEN_W +: LEN_W];
        sel_tag_c    = bus.s_tcq_tag[i*CH_TAG_BITS +: CH_TAG_BITS];
      end
    end
  end

  // Completions return with zero latency: the tag's top bits name the owning channel
  assign cpl_ch_c = bus.m_tcq_ctag[PCIE_TAG_BITS-1 -: CH_BITS];

  always_comb begin
    cpl_valid_c           = '0;
    cpl_valid_c[cpl_ch_c] = bus.m_tcq_cvalid;
  end

  assign bus.s_tcq_cvalid = cpl_valid_c;
  assign bus.s_tcq_ctag   = bus.m_tcq_ctag[CH_TAG_BITS-1:0];
  assign bus.m_tcq_cready = bus.s_tcq_cready[cpl_ch_c];
  assign cpl_hs_c         = bus.m_tcq_cvalid && bus.s_tcq_cready[cpl_ch_c];

  always_comb begin
    inc_c = '0;
    dec_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      inc_c[i] = grant_c[i];
      dec_c[i] = cpl_hs_c && (cpl_ch_c == CH_BITS'(i));
    end
  end

  // Output slot and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      m_laddr_q  <= '0;
      m_raddr_q  <= '0;
      m_length_q <= '0;
      m_tag_q    <= '0;
      rr_ptr     <= '0;
    end else if (accept_c) begin
      m_valid_q  <= 1'b1;
      m_laddr_q  <= sel_laddr_c;
      m_raddr_q  <= sel_raddr_c;
      m_length_q <= sel_length_c;
      m_tag_q    <= {grant_idx_c, sel_tag_c};
      rr_ptr     <= grant_idx_c + CH_BITS'(1);
    end else if (bus.m_tcq_ready) begin
      m_valid_q  <= 1'b0;
    end
  end

  // In-flight counters; a simultaneous issue and completion cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_underflow <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        outstanding[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (inc_c[i] && !dec_c[i]) begin
          outstanding[i] <= outstanding[i] + CNT_W'(1);
        end else if (dec_c[i] && !inc_c[i]) begin
          if (outstanding[i] == '0) begin
            cpl_underflow[i] <= 1'b1;
          end else begin
            outstanding[i] <= outstanding[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.m_tcq_valid  = m_valid_q;
  assign bus.m_tcq_laddr  = m_laddr_q;
  assign bus.m_tcq_raddr  = m_raddr_q;
  assign bus.m_tcq_length = m_length_q;
  assign bus.m_tcq_tag    = m_tag_q;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_stat
    assign stat_outstanding[g*CNT_W +: CNT_W] = outstanding[g];
  end

  assign stat_cpl_underflow = cpl_underflow;

endmodule

// File: tb/tb_dma_tcq_arbiter.sv
// Bench for dma_tcq_arbiter: directed scenarios with literal expectations, then random
// traffic, all shadowed by a behavioural model compared every cycle.
module tb_dma_tcq_arbiter;
  localparam int unsigned CH   = 2;
  localparam int unsigned RAW  = 17;
  localparam int unsigned BAW  = 32;
  localparam int unsigned DB   = 3;
  localparam int unsigned RLB  = 12;
  localparam int unsigned PTB  = 5;
  localparam int unsigned CTB  = PTB - 1;
  localparam int unsigned MAXO = 4;
  localparam int unsigned LW   = RAW - DB;
  localparam int unsigned RW   = BAW - DB;
  localparam int unsigned LENW = RLB - DB;
  localparam int unsigned CNTW = CTB + 1;

  logic clk;
  logic rst;
  logic [CH*CNTW-1:0] stat_outstanding;
  logic [CH-1:0]      stat_cpl_underflow;

  dma_tcq_arbiter_if #(.CHANNELS(CH), .RAM_ADDR_WIDTH(RAW), .BUS_ADDR_WIDTH(BAW),
                       .DATA_BITS(DB), .REQUEST_LEN_BITS(RLB), .PCIE_TAG_BITS(PTB)) bus ();

  dma_tcq_arbiter #(.CHANNELS(CH), .RAM_ADDR_WIDTH(RAW), .BUS_ADDR_WIDTH(BAW),
                    .DATA_BITS(DB), .REQUEST_LEN_BITS(RLB), .PCIE_TAG_BITS(PTB),
                    .MAX_OUTSTANDING(MAXO)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .stat_outstanding   (stat_outstanding),
    .stat_cpl_underflow (stat_cpl_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: counts per channel, pointer as an int, one output slot
  int              m_cnt [CH];
  bit              m_uf  [CH];
  int              m_rr;
  bit              m_mv;
  logic [LW-1:0]   m_la;
  logic [RW-1:0]   m_ra;
  logic [LENW-1:0] m_len;
  logic [PTB-1:0]  m_tag;

  function automatic int model_grant();
    if (rst || (m_mv && !bus.m_tcq_ready)) return -1;
    for (int k = 0; k < int'(CH); k++) begin
      int c;
      c = (m_rr + k) % int'(CH);
      if (bus.s_tcq_valid[c] && m_cnt[c] < int'(MAXO)) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    int cc;
    bit chs;
    g   = model_grant();
    cc  = int'(bus.m_tcq_ctag >> CTB);
    chs = bus.m_tcq_cvalid && bus.s_tcq_cready[cc];
    if (rst) begin
      m_rr = 0; m_mv = 0; m_la = '0; m_ra = '0; m_len = '0; m_tag = '0;
      for (int i = 0; i < int'(CH); i++) begin m_cnt[i] = 0; m_uf[i] = 0; end
    end else begin
      if (g >= 0) begin
        m_mv  = 1;
        m_la  = bus.s_tcq_laddr[g*LW +: LW];
        m_ra  = bus.s_tcq_raddr[g*RW +: RW];
        m_len = bus.s_tcq_length[g*LENW +: LENW];
        m_tag = PTB'((g << CTB) | int'(bus.s_tcq_tag[g*CTB +: CTB]));
        m_rr  = (g + 1) % int'(CH);
      end else if (bus.m_tcq_ready) begin
        m_mv = 0;
      end
      if (g >= 0 && !(chs && cc == g)) m_cnt[g]++;
      if (chs && cc != g) begin
        if (m_cnt[cc] == 0) m_uf[cc] = 1;
        else m_cnt[cc]--;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    int g;
    int cc;
    logic [CH-1:0] exp_ready;
    logic [CH-1:0] exp_cvalid;
    if (check_en) begin
      g = model_grant();
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      cc = int'(bus.m_tcq_ctag >> CTB);
      exp_cvalid = '0;
      exp_cvalid[cc] = bus.m_tcq_cvalid;
      chk("s_tcq_ready", bus.s_tcq_ready, exp_ready);
      chk("m_tcq_valid", bus.m_tcq_valid, m_mv);
      chk("m_tcq_laddr", bus.m_tcq_laddr, m_la);
      chk("m_tcq_raddr", bus.m_tcq_raddr, m_ra);
      chk("m_tcq_length", bus.m_tcq_length, m_len);
      chk("m_tcq_tag", bus.m_tcq_tag, m_tag);
      chk("s_tcq_cvalid", bus.s_tcq_cvalid, exp_cvalid);
      chk("s_tcq_ctag", bus.s_tcq_ctag, bus.m_tcq_ctag % (1 << CTB));
      chk("m_tcq_cready", bus.m_tcq_cready, bus.s_tcq_cready[cc]);
      for (int i = 0; i < int'(CH); i++) begin
        chk($sformatf("stat_outstanding[%0d]", i), stat_outstanding[i*CNTW +: CNTW], m_cnt[i]);
        chk($sformatf("stat_cpl_underflow[%0d]", i), stat_cpl_underflow[i], m_uf[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    bus.s_tcq_valid  = '0;
    bus.s_tcq_cready = '0;
    bus.m_tcq_ready  = 1'b1;
    bus.m_tcq_cvalid = 1'b0;
    bus.m_tcq_ctag   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int stat(input int i);
    return int'(stat_outstanding[i*CNTW +: CNTW]);
  endfunction

  task automatic set_tag(input int c, input int t);
    bus.s_tcq_tag[c*CTB +: CTB] = CTB'(t);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.s_tcq_laddr  = '0;
    bus.s_tcq_raddr  = '0;
    bus.s_tcq_length = '0;
    bus.s_tcq_tag    = '0;
    bus.s_tcq_valid  = 2'b11;

    // Reset state, ready held low under reset
    tick();
    check_en = 1'b1;
    settle();
    chk("rst_ready", bus.s_tcq_ready, 2'b00);
    chk("rst_mvalid", bus.m_tcq_valid, 1'b0);
    chk("rst_mtag", bus.m_tcq_tag, 5'h00);
    chk("rst_stat", stat_outstanding, '0);
    chk("rst_underflow", stat_cpl_underflow, 2'b00);
    tick();
    rst = 1'b0;

    // Channel 0 streams four requests
    bus.s_tcq_valid = 2'b01;
    bus.s_tcq_length[0 +: LENW] = LENW'(9'h40);
    set_tag(0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) set_tag(0, k + 1);
      else bus.s_tcq_valid = 2'b00;
      settle();
      chk("single_valid", bus.m_tcq_valid, 1'b1);
      chk("single_tag", bus.m_tcq_tag, 64'(k));
      chk("single_stat", 64'(stat(0)), 64'(k + 1));
    end
    tick();
    settle();
    chk("single_drain", bus.m_tcq_valid, 1'b0);
    chk("single_stat4", 64'(stat(0)), 64'd4);

    // Limit: ch0 full, ch1 granted; one completion re-enables ch0
    bus.s_tcq_valid = 2'b10;
    set_tag(1, 5);
    tick();
    bus.s_tcq_valid = 2'b11;
    settle();
    chk("limit_skip", bus.s_tcq_ready, 2'b10);
    tick();
    bus.s_tcq_valid  = 2'b01;
    bus.m_tcq_cvalid = 1'b1;
    bus.m_tcq_ctag   = 5'b0_0010;
    bus.s_tcq_cready = 2'b01;
    settle();
    chk("limit_block", bus.s_tcq_ready, 2'b00);
    chk("cpl0_cvalid", bus.s_tcq_cvalid, 2'b01);
    chk("cpl0_ctag", bus.s_tcq_ctag, 4'h2);
    chk("cpl0_cready", bus.m_tcq_cready, 1'b1);
    tick();
    bus.m_tcq_cvalid = 1'b0;
    settle();
    chk("limit_reenable", bus.s_tcq_ready, 2'b01);
    chk("limit_stat", 64'(stat(0)), 64'd3);
    tick();
    do_reset();

    // Contention: alternating grants from ch0
    bus.s_tcq_valid = 2'b11;
    set_tag(0, 1);
    set_tag(1, 2);
    bus.s_tcq_laddr[0 +: LW]  = LW'(3);
    bus.s_tcq_laddr[LW +: LW] = LW'(7);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) bus.m_tcq_ready = 1'b0;
      settle();
      chk("rr_tag", bus.m_tcq_tag, (k % 2 == 0) ? 5'h01 : 5'h12);
    end

    // Backpressure: slot holds ch1's request while the channel payloads move
    for (int j = 0; j < 5; j++) begin
      bus.s_tcq_laddr[LW +: LW] = LW'($urandom);
      settle();
      chk("bp_ready", bus.s_tcq_ready, 2'b00);
      chk("bp_valid", bus.m_tcq_valid, 1'b1);
      chk("bp_tag", bus.m_tcq_tag, 5'h12);
      chk("bp_laddr", bus.m_tcq_laddr, 64'd7);
      chk("bp_stat", {32'(stat(0)), 32'(stat(1))}, {32'd3, 32'd3});
      tick();
    end
    bus.m_tcq_ready = 1'b1;
    settle();
    chk("bp_release", bus.s_tcq_ready, 2'b01);
    tick();
    do_reset();

    // Completion routing and same-cycle issue/complete
    bus.m_tcq_cvalid = 1'b1;
    bus.m_tcq_ctag   = 5'b1_0011;
    bus.s_tcq_cready = 2'b01;
    settle();
    chk("route_cvalid", bus.s_tcq_cvalid, 2'b10);
    chk("route_ctag", bus.s_tcq_ctag, 4'h3);
    chk("route_cready", bus.m_tcq_cready, 1'b0);
    bus.m_tcq_cvalid = 1'b0;
    bus.s_tcq_valid  = 2'b10;
    tick();
    bus.m_tcq_cvalid = 1'b1;
    bus.s_tcq_cready = 2'b11;
    tick();
    idle();
    settle();
    chk("same_cycle_stat", 64'(stat(1)), 64'd1);
    do_reset();

    // Underflow, then reset while a request is pending
    bus.m_tcq_cvalid = 1'b1;
    bus.m_tcq_ctag   = 5'b0_0001;
    bus.s_tcq_cready = 2'b01;
    tick();
    idle();
    settle();
    chk("uf_flag", stat_cpl_underflow, 2'b01);
    chk("uf_count", 64'(stat(0)), 64'd0);
    bus.s_tcq_valid = 2'b01;
    tick();
    bus.s_tcq_valid = 2'b00;
    bus.m_tcq_ready = 1'b0;
    settle();
    chk("pre_rst_valid", bus.m_tcq_valid, 1'b1);
    rst = 1'b1;
    tick();
    settle();
    chk("mid_rst_valid", bus.m_tcq_valid, 1'b0);
    chk("mid_rst_stat", stat_outstanding, '0);
    chk("mid_rst_uf", stat_cpl_underflow, 2'b00);
    rst = 1'b0;
    idle();

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      int cc;
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < int'(CH); i++) begin
        bus.s_tcq_valid[i] = ($urandom_range(0, 9) < 6);
        bus.s_tcq_laddr[i*LW +: LW]     = LW'($urandom);
        bus.s_tcq_raddr[i*RW +: RW]     = RW'($urandom);
        bus.s_tcq_length[i*LENW +: LENW] = LENW'($urandom);
        bus.s_tcq_tag[i*CTB +: CTB]     = CTB'($urandom);
        bus.s_tcq_cready[i] = ($urandom_range(0, 3) != 0);
      end
      bus.m_tcq_ready = ($urandom_range(0, 9) < 7);
      cc = int'($urandom_range(0, CH - 1));
      bus.m_tcq_ctag = PTB'((cc << CTB) | int'($urandom_range(0, (1 << CTB) - 1)));
      if (m_cnt[cc] > 0) bus.m_tcq_cvalid = ($urandom_range(0, 1) == 1);
      else bus.m_tcq_cvalid = ($urandom_range(0, 49) == 0);
    end
    rst = 1'b0;
    idle();
    tick();
    tick();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
